// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding one shared UART shift register.
// Latches byte and frame config, strobes send, waits for done.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 1
) (
  input  logic                 baud_out,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_done,
  input  logic [1:0]           cfg_parity_type,
  input  logic                 cfg_stop_bits,
  input  logic                 cfg_data_lenth,
  output logic [7:0]           tx_data,
  output logic [1:0]           parity_type,
  output logic                 stop_bits,
  output logic                 data_lenth,
  output logic                 send,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t              r_state, w_nxt;
  logic [ID_W-1:0]     r_grant, w_grant;
  logic [ID_W-1:0]     r_last, w_last;
  logic [15:0]         r_wd, w_wd;
  logic [7:0]          r_gap, w_gap;
  logic [NUM_REQ-1:0]  r_ready, w_ready;
  logic [NUM_REQ-1:0]  r_done, w_done;
  logic [7:0]          r_data, w_data;
  logic [1:0]          r_par, w_par;
  logic                r_stop, w_stop;
  logic                r_len, w_len;
  logic                r_send, w_send;
  logic                r_busy, w_busy;
  logic                r_tmo, w_tmo;
  logic                w_any;
  logic [ID_W-1:0]     w_pick;
  logic                w_unused;

  // Busy indication from the shift register is not needed to sequence.
  assign w_unused = tx_active;

  always_comb begin
    logic [ID_W-1:0] idx;
    w_any  = 1'b0;
    w_pick = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = r_last + ID_W'(i);
      if (!w_any && req_valid[idx]) begin
        w_any  = 1'b1;
        w_pick = idx;
      end
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_grant = r_grant;
    w_last  = r_last;
    w_wd    = r_wd;
    w_gap   = r_gap;
    w_ready = '0;
    w_done  = '0;
    w_data  = r_data;
    w_par   = r_par;
    w_stop  = r_stop;
    w_len   = r_len;
    w_send  = 1'b1;
    w_tmo   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant = w_pick;
          w_ready = ONE << w_pick;
          w_nxt   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_data = req_data[r_grant*8 +: 8];
        w_par  = cfg_parity_type;
        w_stop = cfg_stop_bits;
        w_len  = cfg_data_lenth;
        w_last = r_grant;
        w_send = 1'b0;
        w_nxt  = S_SEND;
      end
      S_SEND: begin
        w_wd  = '0;
        w_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done || r_wd == WD_LAST) begin
          w_done = ONE << r_grant;
          w_tmo  = !tx_done;
          w_gap  = '0;
          if (GAP_CYCLES == 0) w_nxt = S_IDLE;
          else w_nxt = S_GAP;
        end else begin
          w_wd = r_wd + 16'd1;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_nxt = S_IDLE;
        else w_gap = r_gap + 8'd1;
      end
      default: w_nxt = S_IDLE;
    endcase
    w_busy = (w_nxt != S_IDLE);
  end

  always_ff @(posedge baud_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= ID_W'(NUM_REQ - 1);
      r_wd    <= '0;
      r_gap   <= '0;
      r_ready <= '0;
      r_done  <= '0;
      r_data  <= '0;
      r_par   <= '0;
      r_stop  <= 1'b0;
      r_len   <= 1'b0;
      r_send  <= 1'b1;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_grant <= w_grant;
      r_last  <= w_last;
      r_wd    <= w_wd;
      r_gap   <= w_gap;
      r_ready <= w_ready;
      r_done  <= w_done;
      r_data  <= w_data;
      r_par   <= w_par;
      r_stop  <= w_stop;
      r_len   <= w_len;
      r_send  <= w_send;
      r_busy  <= w_busy;
      r_tmo   <= w_tmo;
    end
  end

  assign req_ready   = r_ready;
  assign req_done    = r_done;
  assign tx_data     = r_data;
  assign parity_type = r_par;
  assign stop_bits   = r_stop;
  assign data_lenth  = r_len;
  assign send        = r_send;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (4 requesters,
// 64-cycle watchdog, 1-cycle gap).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready, req_done;
  logic [1:0]  cfg_parity_type = '0;
  logic        cfg_stop_bits = 1'b0;
  logic        cfg_data_lenth = 1'b0;
  logic [7:0]  tx_data;
  logic [1:0]  parity_type;
  logic        stop_bits, data_lenth, send;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic [1:0]  grant_id;
  logic        busy, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler dut (
    .baud_out        (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .req_done        (req_done),
    .cfg_parity_type (cfg_parity_type),
    .cfg_stop_bits   (cfg_stop_bits),
    .cfg_data_lenth  (cfg_data_lenth),
    .tx_data         (tx_data),
    .parity_type     (parity_type),
    .stop_bits       (stop_bits),
    .data_lenth      (data_lenth),
    .send            (send),
    .tx_active       (tx_active),
    .tx_done         (tx_done),
    .grant_id        (grant_id),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full grant from IDLE; tx_done arrives dly cycles into WAIT_DONE.
  task automatic xfer(input int id, input logic [7:0] d,
                      input int dly, input logic drop);
    tick();
    chk("ready", req_ready, 32'(4'b1 << id));
    chk("grant", grant_id, id);
    chk("busy", busy, 1);
    tick();
    if (drop) req_valid[id] = 1'b0;
    chk("send_lo", send, 0);
    chk("ready_clr", req_ready, 0);
    chk("txdata", tx_data, d);
    tick();
    chk("send_hi", send, 1);
    repeat (dly) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("done", req_done, 32'(4'b1 << id));
    chk("tmo_none", timeout_err, 0);
    tick();
    chk("done_clr", req_done, 0);
    chk("idle", busy, 0);
  endtask

  initial begin
    int early;
    #12;
    chk("rst_send", send, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", req_done, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_par", parity_type, 0);
    chk("rst_stop", stop_bits, 0);
    chk("rst_len", data_lenth, 0);
    chk("rst_grant", grant_id, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single request with config hold check
    req_data = 32'h4433_22A5;
    cfg_parity_type = 2'b01;
    cfg_stop_bits = 1'b1;
    cfg_data_lenth = 1'b1;
    req_valid = 4'b0001;
    tick();
    chk("s_ready", req_ready, 4'b0001);
    chk("s_send_hi", send, 1);
    tick();
    req_valid = 4'b0000;
    chk("s_send_lo", send, 0);
    chk("s_txdata", tx_data, 8'hA5);
    chk("s_par", parity_type, 2'b01);
    tick();
    chk("s_send_back", send, 1);
    tx_active = 1'b1;
    cfg_parity_type = 2'b10;
    cfg_stop_bits = 1'b0;
    cfg_data_lenth = 1'b0;
    req_data = 32'h0000_0000;
    repeat (3) tick();
    chk("h_par", parity_type, 2'b01);
    chk("h_stop", stop_bits, 1);
    chk("h_len", data_lenth, 1);
    chk("h_data", tx_data, 8'hA5);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_active = 1'b0;
    chk("s_done", req_done, 4'b0001);
    chk("s_busy_gap", busy, 1);
    tick();
    chk("s_done_clr", req_done, 0);
    chk("s_busy_off", busy, 0);

    // round robin: all valid, grant 1,2,3,0 after last=0
    req_data = 32'h4433_2211;
    req_valid = 4'b1111;
    xfer(1, 8'h22, 2, 1'b0);
    xfer(2, 8'h33, 0, 1'b0);
    xfer(3, 8'h44, 1, 1'b0);
    xfer(0, 8'h11, 0, 1'b0);
    xfer(1, 8'h22, 0, 1'b0);
    req_valid = 4'b0000;
    tick();

    // priority wrap: last=1, so 0100 -> 2; then 0011 -> 0
    req_valid = 4'b0100;
    xfer(2, 8'h33, 0, 1'b1);
    req_valid = 4'b0011;
    xfer(0, 8'h11, 0, 1'b1);
    req_valid = 4'b0000;
    req_valid = 4'b0100;
    xfer(2, 8'h33, 0, 1'b1);
    req_valid = 4'b1010;
    xfer(3, 8'h44, 0, 1'b0);
    xfer(1, 8'h22, 0, 1'b0);
    req_valid = 4'b0000;
    tick();

    // watchdog expiry, 64 cycles after WAIT_DONE entry
    req_valid = 4'b0001;
    tick();
    tick();
    req_valid = 4'b0000;
    tick();
    early = 0;
    repeat (63) begin
      tick();
      if (timeout_err || req_done != 4'b0) early++;
    end
    chk("wd_early", early, 0);
    tick();
    chk("wd_tmo", timeout_err, 1);
    chk("wd_done", req_done, 4'b0001);
    tick();
    chk("wd_tmo_clr", timeout_err, 0);
    chk("wd_idle", busy, 0);

    // tx_done on the expiry cycle wins over timeout
    req_valid = 4'b0010;
    tick();
    tick();
    req_valid = 4'b0000;
    tick();
    repeat (63) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("tie_done", req_done, 4'b0010);
    chk("tie_tmo", timeout_err, 0);
    tick();

    // reset during WAIT_DONE
    req_data = 32'h4433_2211;
    req_valid = 4'b0100;
    tick();
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("mr_send", send, 1);
    chk("mr_busy", busy, 0);
    chk("mr_data", tx_data, 0);
    chk("mr_grant", grant_id, 0);
    tick();
    chk("mr_done", req_done, 0);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    xfer(0, 8'h11, 0, 1'b0);
    req_valid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
